// File: rtl/msrv32_bpu_if.sv
// Purpose: fetch-side prediction port and execute-side resolution port of msrv32_bpu.
// Latency: prediction is combinational; resolution results are registered, one cycle.
// Backpressure: none; the execute side may present a resolution every cycle.
//
// Port summary:
//   fetch      : fetch_pc_in -> predict_taken_out
//   execute    : ex_valid_in, flush_in, opcode_6_to_2_in, funct3_in, rs1_in, rs2_in,
//                ex_pc_in, ex_pred_taken_in
//   resolution : resolve_valid_out, branch_taken_out, mispredict_out
//   statistics : branch_count_out, mispredict_count_out
// master = pipeline side driving the unit, slave = the unit itself.
interface msrv32_bpu_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  // fetch side
  logic [XLEN-1:0]  fetch_pc_in;
  logic             predict_taken_out;

  // execute side
  logic             ex_valid_in;
  logic             flush_in;
  logic [4:0]       opcode_6_to_2_in;
  logic [2:0]       funct3_in;
  logic [XLEN-1:0]  rs1_in;
  logic [XLEN-1:0]  rs2_in;
  logic [XLEN-1:0]  ex_pc_in;
  logic             ex_pred_taken_in;

  // registered resolution results
  logic             resolve_valid_out;
  logic             branch_taken_out;
  logic             mispredict_out;

  // saturating statistics
  logic [CNT_W-1:0] branch_count_out;
  logic [CNT_W-1:0] mispredict_count_out;

  modport master (
    output fetch_pc_in,
    output ex_valid_in, flush_in, opcode_6_to_2_in, funct3_in,
    output rs1_in, rs2_in, ex_pc_in, ex_pred_taken_in,
    input  predict_taken_out,
    input  resolve_valid_out, branch_taken_out, mispredict_out,
    input  branch_count_out, mispredict_count_out
  );

  modport slave (
    input  fetch_pc_in,
    input  ex_valid_in, flush_in, opcode_6_to_2_in, funct3_in,
    input  rs1_in, rs2_in, ex_pc_in, ex_pred_taken_in,
    output predict_taken_out,
    output resolve_valid_out, branch_taken_out, mispredict_out,
    output branch_count_out, mispredict_count_out
  );
endinterface

// File: rtl/msrv32_bpu.sv
// Purpose: resolves BRANCH/JAL/JALR and predicts from a PC-indexed table of 2-bit counters.
// Latency: prediction 0 cycles (combinational); resolution/mispredict 1 cycle (registered).
// Backpressure: none; one resolution per cycle accepted, flush squashes without side effects.
//
// Ports:
//   clk_in    : single clock, all state on rising edge
//   rst_n_in  : asynchronous active-low reset (table -> weakly not taken, outputs/counters -> 0)
//   bus       : msrv32_bpu_if.slave (fetch prediction, execute resolution, statistics)
module msrv32_bpu #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 32
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  msrv32_bpu_if.slave   bus
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Decoded view of the execute-stage instruction.
  typedef struct packed {
    logic is_branch;
    logic is_jump;     // JAL or JALR
    logic f3_legal;    // funct3 names a real branch condition
  } dec_t;

  // --------------------------------------------------------------------------
  // Branch history table
  // --------------------------------------------------------------------------
  logic [1:0]       bht [BHT_DEPTH];
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [1:0]       ex_ctr;
  logic [1:0]       ex_ctr_next;

  // Word-aligned PCs: bits [1:0] carry no information, upper bits alias.
  assign fetch_idx = bus.fetch_pc_in[IDX_W+1:2];
  assign ex_idx    = bus.ex_pc_in[IDX_W+1:2];

  // Reads the pre-update array, so a same-cycle write to this index shows next cycle.
  assign bus.predict_taken_out = bht[fetch_idx][1];

  // Address bits outside the index field are deliberately ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.fetch_pc_in[XLEN-1:IDX_W+2], bus.fetch_pc_in[1:0],
                            bus.ex_pc_in[XLEN-1:IDX_W+2], bus.ex_pc_in[1:0]};

  // --------------------------------------------------------------------------
  // Decode and condition evaluation
  // --------------------------------------------------------------------------
  dec_t dec;
  logic accept;
  logic cond_true;
  logic taken;
  logic mispred;
  logic train;
  logic ops_eq;
  logic ops_lt_s;
  logic ops_lt_u;

  assign accept = bus.ex_valid_in & ~bus.flush_in;

  always_comb begin
    dec           = '0;
    dec.is_branch = (bus.opcode_6_to_2_in == OP_BRANCH);
    dec.is_jump   = (bus.opcode_6_to_2_in == OP_JAL) || (bus.opcode_6_to_2_in == OP_JALR);
    // 010 and 011 are the only unused encodings in the branch funct3 space.
    dec.f3_legal  = (bus.funct3_in[2:1] != 2'b01);
  end

  assign ops_eq   = (bus.rs1_in == bus.rs2_in);
  assign ops_lt_s = ($signed(bus.rs1_in) < $signed(bus.rs2_in));
  assign ops_lt_u = (bus.rs1_in < bus.rs2_in);

  always_comb begin
    cond_true = 1'b0;
    unique case (bus.funct3_in)
      3'b000:  cond_true = ops_eq;
      3'b001:  cond_true = ~ops_eq;
      3'b100:  cond_true = ops_lt_s;
      3'b101:  cond_true = ~ops_lt_s;
      3'b110:  cond_true = ops_lt_u;
      3'b111:  cond_true = ~ops_lt_u;
      default: cond_true = 1'b0;
    endcase
  end

  // Jumps are always taken; anything that is not a control instruction is not taken.
  assign taken   = dec.is_branch ? cond_true : dec.is_jump;
  assign mispred = taken ^ bus.ex_pred_taken_in;
  assign train   = accept & dec.is_branch & dec.f3_legal;

  // --------------------------------------------------------------------------
  // Table training: 2-bit saturating counter step
  // --------------------------------------------------------------------------
  assign ex_ctr = bht[ex_idx];

  always_comb begin
    ex_ctr_next = ex_ctr;
    if (taken) begin
      if (ex_ctr != 2'b11) ex_ctr_next = ex_ctr + 2'd1;
    end else begin
      if (ex_ctr != 2'b00) ex_ctr_next = ex_ctr - 2'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
    end else if (train) begin
      bht[ex_idx] <= ex_ctr_next;
    end
  end

  // --------------------------------------------------------------------------
  // Registered resolution results: one-cycle pulses, cleared when nothing accepted
  // --------------------------------------------------------------------------
  logic resolve_valid_q;
  logic branch_taken_q;
  logic mispredict_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      resolve_valid_q <= 1'b0;
      branch_taken_q  <= 1'b0;
      mispredict_q    <= 1'b0;
    end else begin
      resolve_valid_q <= accept;
      branch_taken_q  <= accept & taken;
      mispredict_q    <= accept & mispred;
    end
  end

  assign bus.resolve_valid_out = resolve_valid_q;
  assign bus.branch_taken_out  = branch_taken_q;
  assign bus.mispredict_out    = mispredict_q;

  // --------------------------------------------------------------------------
  // Statistics: saturate at all-ones so long runs never wrap back to small values
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] mispred_cnt_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (train && (branch_cnt_q != CNT_MAX)) begin
        branch_cnt_q <= branch_cnt_q + CNT_ONE;
      end
      if (accept && mispred && (mispred_cnt_q != CNT_MAX)) begin
        mispred_cnt_q <= mispred_cnt_q + CNT_ONE;
      end
    end
  end

  assign bus.branch_count_out     = branch_cnt_q;
  assign bus.mispredict_count_out = mispred_cnt_q;

endmodule

// File: tb/tb_msrv32_bpu.sv
// Purpose: self-checking bench for msrv32_bpu with a behavioural reference model.
// Latency: model mirrors the one-cycle resolution and zero-cycle prediction.
// Backpressure: none; stimulus may issue every cycle.
module tb_msrv32_bpu;

  localparam int XLEN  = 32;
  localparam int DEPTH = 64;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  localparam logic [4:0] BR  = 5'b11000;
  localparam logic [4:0] JAL = 5'b11011;
  localparam logic [4:0] JLR = 5'b11001;
  localparam logic [4:0] ADD = 5'b01100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  msrv32_bpu_if #(.XLEN(XLEN), .CNT_W(CW)) bus ();

  msrv32_bpu #(.XLEN(XLEN), .BHT_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: counters as plain integers, rules straight from the ISA
  // ---------------------------------------------------------------------------
  int m_bht [DEPTH];
  bit m_rv, m_tk, m_mp;
  int m_bc, m_mc;

  function automatic bit ref_taken(input logic [4:0] op, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (op == JAL || op == JLR) return 1'b1;
    if (op != BR) return 1'b0;
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit acc, tk;
    int ix;
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
      m_rv = 0; m_tk = 0; m_mp = 0; m_bc = 0; m_mc = 0;
    end else begin
      acc  = bus.ex_valid_in && !bus.flush_in;
      tk   = ref_taken(bus.opcode_6_to_2_in, bus.funct3_in, bus.rs1_in, bus.rs2_in);
      m_rv = acc;
      m_tk = acc && tk;
      m_mp = acc && (tk != bus.ex_pred_taken_in);
      if (acc && bus.opcode_6_to_2_in == BR && bus.funct3_in != 3'd2 && bus.funct3_in != 3'd3) begin
        ix = idx_of(bus.ex_pc_in);
        if (tk) m_bht[ix] = (m_bht[ix] < 3) ? m_bht[ix] + 1 : 3;
        else    m_bht[ix] = (m_bht[ix] > 0) ? m_bht[ix] - 1 : 0;
        if (m_bc < CMAX) m_bc++;
      end
      if (m_mp && m_mc < CMAX) m_mc++;
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_predict", bus.predict_taken_out, 32'(m_bht[idx_of(bus.fetch_pc_in)] >= 2));
      chk("cyc_resolve_valid", bus.resolve_valid_out, 32'(m_rv));
      chk("cyc_branch_taken", bus.branch_taken_out, 32'(m_tk));
      chk("cyc_mispredict", bus.mispredict_out, 32'(m_mp));
      chk("cyc_branch_count", 32'(bus.branch_count_out), 32'(m_bc));
      chk("cyc_mispredict_count", 32'(bus.mispredict_count_out), 32'(m_mc));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called at posedge+1)
  // ---------------------------------------------------------------------------
  task automatic idle();
    bus.ex_valid_in      = 1'b0;
    bus.flush_in         = 1'b0;
    bus.opcode_6_to_2_in = ADD;
    bus.funct3_in        = 3'd0;
    bus.rs1_in           = '0;
    bus.rs2_in           = '0;
    bus.ex_pc_in         = '0;
    bus.ex_pred_taken_in = 1'b0;
  endtask

  task automatic issue(input logic [4:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] pc, input bit pred, input bit fl);
    bus.ex_valid_in      = 1'b1;
    bus.flush_in         = fl;
    bus.opcode_6_to_2_in = op;
    bus.funct3_in        = f3;
    bus.rs1_in           = a;
    bus.rs2_in           = b;
    bus.ex_pc_in         = pc;
    bus.ex_pred_taken_in = pred;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios followed by randomized traffic
  // ---------------------------------------------------------------------------
  initial begin
    idle();
    bus.fetch_pc_in = 32'h1234_5678;
    rst_n = 1'b0;
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_predict", bus.predict_taken_out, 0);
    chk("rst_resolve_valid", bus.resolve_valid_out, 0);
    chk("rst_branch_count", 32'(bus.branch_count_out), 0);
    chk("rst_mispredict_count", 32'(bus.mispredict_count_out), 0);
    rst_n = 1'b1;

    // BEQ taken twice at 0x100: 01 -> 10 -> 11, aliasing with 0x200
    bus.fetch_pc_in = 32'h100;
    issue(BR, 3'd0, 32'd5, 32'd5, 32'h100, 1'b0, 1'b0);
    chk("beq1_valid", bus.resolve_valid_out, 1);
    chk("beq1_taken", bus.branch_taken_out, 1);
    chk("beq1_mispredict", bus.mispredict_out, 1);
    chk("beq1_predict", bus.predict_taken_out, 1);
    chk("model_beq1_ctr", 32'(m_bht[0]), 2);
    issue(BR, 3'd0, 32'd5, 32'd5, 32'h100, 1'b0, 1'b0);
    idle();
    chk("model_beq2_ctr", 32'(m_bht[0]), 3);
    bus.fetch_pc_in = 32'h200;
    #1;
    chk("alias_predict", bus.predict_taken_out, 1);
    chk("beq_branch_count", 32'(bus.branch_count_out), 2);

    // Signed vs unsigned comparisons
    issue(BR, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h300, 1'b0, 1'b0);
    chk("blt_taken", bus.branch_taken_out, 1);
    issue(BR, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h300, 1'b0, 1'b0);
    chk("bltu_taken", bus.branch_taken_out, 0);
    issue(BR, 3'd5, 32'h8000_0000, 32'h7FFF_FFFF, 32'h300, 1'b0, 1'b0);
    chk("bge_taken", bus.branch_taken_out, 0);
    idle();

    // JAL then ADD back-to-back, both mispredicted, table untouched
    do_reset();
    bus.fetch_pc_in = 32'h400;
    issue(JAL, 3'd0, 32'd0, 32'd0, 32'h400, 1'b0, 1'b0);
    chk("jal_taken", bus.branch_taken_out, 1);
    chk("jal_mispredict", bus.mispredict_out, 1);
    issue(ADD, 3'd0, 32'd1, 32'd2, 32'h400, 1'b1, 1'b0);
    idle();
    chk("add_valid", bus.resolve_valid_out, 1);
    chk("add_taken", bus.branch_taken_out, 0);
    chk("add_mispredict", bus.mispredict_out, 1);
    step();
    chk("idle_valid_cleared", bus.resolve_valid_out, 0);
    chk("jal_add_mispredict_count", 32'(bus.mispredict_count_out), 2);
    chk("jal_add_branch_count", 32'(bus.branch_count_out), 0);
    chk("jal_add_predict", bus.predict_taken_out, 0);

    // Flush wins over valid; illegal funct3 is not trained
    do_reset();
    bus.fetch_pc_in = 32'h500;
    issue(BR, 3'd1, 32'd1, 32'd2, 32'h500, 1'b0, 1'b1);
    idle();
    chk("flush_valid", bus.resolve_valid_out, 0);
    chk("flush_mispredict_count", 32'(bus.mispredict_count_out), 0);
    chk("flush_predict", bus.predict_taken_out, 0);
    issue(BR, 3'd2, 32'd7, 32'd7, 32'h500, 1'b0, 1'b0);
    chk("illegal_valid", bus.resolve_valid_out, 1);
    chk("illegal_taken", bus.branch_taken_out, 0);
    chk("illegal_branch_count", 32'(bus.branch_count_out), 0);
    issue(BR, 3'd0, 32'd7, 32'd7, 32'h500, 1'b0, 1'b0);
    idle();
    chk("illegal_noupd_predict", bus.predict_taken_out, 1);

    // Saturation of statistics and of a table entry at 00
    do_reset();
    repeat (20) issue(BR, 3'd0, 32'd3, 32'd3, 32'h40, 1'b0, 1'b0);
    idle();
    chk("sat_branch_count", 32'(bus.branch_count_out), 15);
    chk("sat_mispredict_count", 32'(bus.mispredict_count_out), 15);
    bus.fetch_pc_in = 32'h80;
    repeat (5) issue(BR, 3'd1, 32'd9, 32'd9, 32'h80, 1'b0, 1'b0);
    idle();
    chk("model_floor_ctr", 32'(m_bht[32]), 0);
    chk("floor_predict", bus.predict_taken_out, 0);
    issue(BR, 3'd0, 32'd1, 32'd1, 32'h80, 1'b0, 1'b0);
    chk("floor_plus1_predict", bus.predict_taken_out, 0);
    issue(BR, 3'd0, 32'd1, 32'd1, 32'h80, 1'b0, 1'b0);
    idle();
    chk("floor_plus2_predict", bus.predict_taken_out, 1);

    // Reset mid-stream clears pending results asynchronously
    issue(BR, 3'd0, 32'd1, 32'd1, 32'h80, 1'b1, 1'b0);
    idle();
    chk("pre_reset_valid", bus.resolve_valid_out, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", bus.resolve_valid_out, 0);
    chk("async_rst_taken", bus.branch_taken_out, 0);
    chk("async_rst_branch_count", 32'(bus.branch_count_out), 0);
    step();
    rst_n = 1'b1;

    // Randomized traffic, including same-index fetch/execute collisions
    for (int n = 0; n < 3000; n++) begin
      int sel;
      logic [4:0] op;
      logic [31:0] a, b, pc;
      sel = $urandom_range(0, 9);
      op  = (sel < 6) ? BR : (sel == 6) ? JAL : (sel == 7) ? JLR : 5'($urandom);
      a   = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      b   = ($urandom_range(0, 2) == 0) ? a : $urandom;
      pc  = 32'($urandom_range(0, 255)) << 2;
      bus.fetch_pc_in = ($urandom_range(0, 2) == 0) ? pc : (32'($urandom_range(0, 255)) << 2);
      bus.ex_valid_in      = ($urandom_range(0, 9) != 0);
      bus.flush_in         = ($urandom_range(0, 7) == 0);
      bus.opcode_6_to_2_in = op;
      bus.funct3_in        = 3'($urandom);
      bus.rs1_in           = a;
      bus.rs2_in           = b;
      bus.ex_pc_in         = pc;
      bus.ex_pred_taken_in = 1'($urandom);
      step();
    end
    idle();
    repeat (2) step();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/msrv32_bpu.md
# msrv32_bpu

Parametrised branch resolution and prediction unit for the msrv32 core: the successor of the combinational branch unit. It resolves BRANCH/JAL/JALR outcomes over an XLEN-wide datapath and keeps a PC-indexed table of 2-bit saturating counters. The fetch stage reads the table for a prediction. Execute-stage resolutions train the table, raise a registered mispredict, and bump saturating statistics counters.

## Interface
Parameters:
- XLEN, 32, operand and PC width (≥ 8)
- BHT_DEPTH, 64, number of 2-bit counters; power of two, ≥ 4
- CNT_W, 32, width of the statistics counters
- IDX_W, derived: log2(BHT_DEPTH)

Ports:
- clk_in  input  1  single clock; all state updates on rising edge
- rst_n_in  input  1  reset, asynchronous and active-low
- fetch_pc_in  input  XLEN  PC of the instruction being fetched
- predict_taken_out  output  1  combinational prediction: MSB of the counter at fetch index
- ex_valid_in  input  1  execute-stage instruction valid this cycle
- flush_in  input  1  squash the execute-stage instruction
- opcode_6_to_2_in  input  5  instruction opcode bits [6:2]
- funct3_in  input  3  branch condition select
- rs1_in, rs2_in  input  XLEN  operands
- ex_pc_in  input  XLEN  PC of the execute-stage instruction
- ex_pred_taken_in  input  1  prediction carried down the pipe with that instruction
- resolve_valid_out  output  1  registered: a resolution was accepted last cycle
- branch_taken_out  output  1  registered: actual outcome
- mispredict_out  output  1  registered: outcome ≠ carried prediction
- branch_count_out  output  CNT_W  conditional branches resolved
- mispredict_count_out  output  CNT_W  mispredicts of any kind

## Operation
- Index = pc[IDX_W+1:2], both for fetch and execute.
- Accept = ex_valid_in & ~flush_in. Flush wins over valid: no outputs are produced and no state is updated.
- Opcodes: BRANCH 11000, JAL 11011, JALR 11001. All others are non-control.
- Condition by funct3 for BRANCH:
  - 000 eq; 001 ne
  - 100 lt signed; 101 ge signed
  - 110 lt unsigned; 111 ge unsigned
  - Signed compares use the full XLEN as two's complement.
  - 010/011 are illegal: taken = 0, no table update, not counted in branch_count_out.
- Outcome by instruction type:
  - JAL/JALR: taken = 1; no table update.
  - Non-control: taken = 0.
- Mispredict = taken ^ ex_pred_taken_in, for every accepted instruction. This includes a non-control instruction carrying a taken prediction.
- Table training applies only to accepted legal BRANCH instructions:
  - Taken: the counter increments, saturating at 2'b11.
  - Not taken: the counter decrements, saturating at 2'b00.
- Statistics counters:
  - branch_count_out increments per accepted legal BRANCH.
  - mispredict_count_out increments per accepted mispredict.
  - Both saturate at all-ones and never wrap.

## Timing
- Reset (asynchronous assert, synchronous release):
  - Every table entry = 2'b01 (weakly not taken).
  - resolve_valid_out, branch_taken_out, mispredict_out = 0.
  - Both statistics counters = 0.
- predict_taken_out has zero latency: it is a combinational read of the current table state.
- Same-cycle fetch read and execute write to one index: the read returns the pre-update value, and the new value is visible the next cycle.
- Resolution latency is 1 cycle:
  - Inputs accepted at edge N appear on the registered outputs after edge N.
  - The outputs hold for exactly one cycle unless another accept follows.
  - Back-to-back accepts every cycle are supported, with no bubbles.
- In a cycle with no accept, resolve_valid_out, branch_taken_out and mispredict_out are 0 on the next cycle.
- Reset asserted mid-stream discards any pending resolution: the outputs clear immediately and asynchronously.

## Test plan
- Reset, then fetch_pc_in at any value → predict_taken_out = 0. All counters are 0 and all outputs are 0.
- BEQ at pc 0x100, rs1 = rs2 = 5, pred 0, accepted twice → the entry goes 01→10→11. The first resolution shows branch_taken_out = 1 and mispredict_out = 1. From then on, predict_taken_out = 1 for pc 0x100 and for 0x200 (which aliases to the same index when BHT_DEPTH = 64).
- BLT with rs1 = 0xFFFFFFFF, rs2 = 1 → taken. BLTU with the same operands → not taken. BGE with rs1 = 0x80000000, rs2 = 0x7FFFFFFF → not taken.
- JAL with pred 0, followed next cycle by ADD (opcode 01100) with pred 1 → two consecutive results, mispredict_out = 1 both times. The table is unchanged. mispredict_count_out = 2 and branch_count_out = 0.
- ex_valid_in = 1 with flush_in = 1 on a taken BNE → resolve_valid_out stays 0 and the table and counters are unchanged. Separately, funct3 = 010 on BRANCH → taken 0 and no update.
- Saturation: with CNT_W = 4, apply 20 accepted mispredicting branches → both counters stick at 15. A table entry driven not-taken 5 times stays at 00.
